// File: rtl/queue_reader_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : queue_reader_pkg
//  Description : Shared definitions for the queue read-side controller:
//                state encoding and default widths shared with the queue.
//  Revision    : 1.0 - initial release
// ============================================================================
package queue_reader_pkg;

  // Default widths, kept identical to the queue and its top-level wrapper.
  localparam int DEFAULT_DATA_WIDTH  = 4;
  localparam int DEFAULT_COUNT_WIDTH = 5;
  localparam int DEFAULT_HOLD_TICKS  = 2;

  // Sequencer state encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // The controller reports busy while it owns the queue read port.
  function automatic logic is_busy_state(input state_e s);
    return (s == ST_POP) || (s == ST_HOLD);
  endfunction

endpackage : queue_reader_pkg
`default_nettype wire

// File: rtl/queue_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : queue_reader
//  Description : Burst-drain sequencer for the queue read port. Pops one
//                entry per pacing window, holds it on a registered display
//                output for HOLD_TICKS tick pulses, then pops the next one.
//                All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module queue_reader
  import queue_reader_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
  parameter int HOLD_TICKS  = DEFAULT_HOLD_TICKS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [COUNT_WIDTH-1:0] burst_len_i,
  input  logic                   empty_i,
  input  logic [DATA_WIDTH-1:0]  read_data_i,
  output logic                   read_cmd_o,
  output logic [DATA_WIDTH-1:0]  data_out_o,
  output logic                   data_valid_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [COUNT_WIDTH-1:0] item_count_o
);

  localparam int HOLD_W = (HOLD_TICKS < 2) ? 1 : $clog2(HOLD_TICKS + 1);
  localparam logic [HOLD_W-1:0]      HOLD_LOAD = HOLD_W'(HOLD_TICKS);
  localparam logic [HOLD_W-1:0]      HOLD_ONE  = HOLD_W'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] burst_q, burst_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   read_cmd_q, read_cmd_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  // Next-state and registered-output decode; strobes default low.
  always_comb begin
    state_d    = state_q;
    burst_d    = burst_q;
    count_d    = count_q;
    hold_d     = hold_q;
    data_d     = data_q;
    read_cmd_d = 1'b0;
    valid_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          burst_d = burst_len_i;
          count_d = '0;
          state_d = ST_POP;
        end
      end

      ST_POP: begin
        if (!empty_i) begin
          // A pop already decided completes even if abort arrives with it.
          read_cmd_d = 1'b1;
          valid_d    = 1'b1;
          data_d     = read_data_i;
          count_d    = (count_q == COUNT_MAX) ? count_q : count_q + COUNT_ONE;
          hold_d     = HOLD_LOAD;
          state_d    = abort_i ? ST_IDLE : ST_HOLD;
        end else begin
          state_d    = abort_i ? ST_IDLE : ST_DONE;
        end
      end

      ST_HOLD: begin
        if (abort_i) begin
          hold_d  = '0;
          state_d = ST_IDLE;
        end else if (tick_i) begin
          hold_d = hold_q - HOLD_ONE;
          if (hold_q == HOLD_ONE) begin
            if ((burst_q != '0) && (count_q == burst_q)) begin
              state_d = ST_DONE;
            end else if (empty_i) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_POP;
            end
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are registered from the next state so they line up with it.
    busy_d = is_busy_state(state_d);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      burst_q    <= '0;
      count_q    <= '0;
      hold_q     <= '0;
      data_q     <= '0;
      read_cmd_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      count_q    <= count_d;
      hold_q     <= hold_d;
      data_q     <= data_d;
      read_cmd_q <= read_cmd_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign read_cmd_o   = read_cmd_q;
  assign data_out_o   = data_q;
  assign data_valid_o = valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign item_count_o = count_q;

endmodule : queue_reader
`default_nettype wire

// File: tb/tb_queue_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_queue_reader
//  Description : Self-checking bench for queue_reader with a small queue
//                model per instance (HOLD_TICKS=2 and HOLD_TICKS=3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_queue_reader;

  localparam int DW = 4;
  localparam int CW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          tick, start, abort;
  logic [CW-1:0] burst_len;

  // Instance A (hold 2) and its queue model
  logic          empty_a, rc_a, dv_a, busy_a, done_a;
  logic [DW-1:0] rdata_a, dout_a;
  logic [CW-1:0] cnt_a;
  logic [DW-1:0] qa [16];
  int            wa = 0, ra = 0, bad_pops = 0;
  logic          flush_a = 1'b0;

  // Instance B (hold 3) and its queue model
  logic          empty_b, rc_b, dv_b, busy_b, done_b;
  logic [DW-1:0] rdata_b, dout_b;
  logic [CW-1:0] cnt_b;
  logic [DW-1:0] qb [16];
  int            wb = 0, rb = 0;

  assign empty_a = (ra == wa);
  assign rdata_a = qa[ra[3:0]];
  assign empty_b = (rb == wb);
  assign rdata_b = qb[rb[3:0]];

  // Queue models pop on the edge where read_cmd is high.
  always @(posedge clk) begin
    if (rc_a) begin
      if (ra == wa) bad_pops <= bad_pops + 1;
      ra <= ra + 1;
    end else if (flush_a) begin
      ra <= wa;
    end
    if (rc_b) begin
      if (rb == wb) bad_pops <= bad_pops + 1;
      rb <= rb + 1;
    end
  end

  queue_reader #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .HOLD_TICKS(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .tick_i(tick), .start_i(start), .abort_i(abort),
    .burst_len_i(burst_len), .empty_i(empty_a), .read_data_i(rdata_a),
    .read_cmd_o(rc_a), .data_out_o(dout_a), .data_valid_o(dv_a),
    .busy_o(busy_a), .done_o(done_a), .item_count_o(cnt_a)
  );

  queue_reader #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .HOLD_TICKS(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .tick_i(tick), .start_i(start), .abort_i(abort),
    .burst_len_i(burst_len), .empty_i(empty_b), .read_data_i(rdata_b),
    .read_cmd_o(rc_b), .data_out_o(dout_b), .data_valid_o(dv_b),
    .busy_o(busy_b), .done_o(done_b), .item_count_o(cnt_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs at a falling edge, let one rising edge consume them,
  // return at the next falling edge with outputs settled.
  task automatic cyc(input logic s, input logic a, input logic t);
    start = s; abort = a; tick = t;
    @(negedge clk);
  endtask

  task automatic load_a(input logic [DW-1:0] v);
    qa[wa[3:0]] = v; wa++;
  endtask

  task automatic load_b(input logic [DW-1:0] v);
    qb[wb[3:0]] = v; wb++;
  endtask

  task automatic flush_queue_a();
    start = 1'b0; abort = 1'b0; tick = 1'b0;
    flush_a = 1'b1;
    @(negedge clk);
    flush_a = 1'b0;
  endtask

  typedef struct {
    logic          start, abort, tick;
    logic          rc, dv;
    logic [DW-1:0] dout;
    logic          busy, done;
    logic [CW-1:0] cnt;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic a, input logic t,
                              input logic rc, input logic dv, input int d,
                              input logic b, input logic dn, input int c);
    vec_t v;
    v.start = s; v.abort = a; v.tick = t; v.rc = rc; v.dv = dv;
    v.dout = DW'(d); v.busy = b; v.done = dn; v.cnt = CW'(c);
    return v;
  endfunction

  vec_t tbl [10];

  initial begin
    int npop, ndone, seen [4];
    int pop_idx [4];
    int done_idx;

    // Burst of 2 from queue {3,4,5}, hold 2; tick in POP is not counted,
    // abort while IDLE is ignored.
    tbl[0] = mk(1, 0, 0,  0, 0, 0, 1, 0, 0);
    tbl[1] = mk(0, 0, 0,  1, 1, 3, 1, 0, 1);
    tbl[2] = mk(0, 0, 1,  0, 0, 3, 1, 0, 1);
    tbl[3] = mk(0, 0, 0,  0, 0, 3, 1, 0, 1);
    tbl[4] = mk(0, 0, 1,  0, 0, 3, 1, 0, 1);
    tbl[5] = mk(0, 0, 1,  1, 1, 4, 1, 0, 2);
    tbl[6] = mk(0, 0, 1,  0, 0, 4, 1, 0, 2);
    tbl[7] = mk(0, 0, 1,  0, 0, 4, 0, 1, 2);
    tbl[8] = mk(0, 0, 0,  0, 0, 4, 0, 0, 2);
    tbl[9] = mk(0, 1, 0,  0, 0, 4, 0, 0, 2);

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; tick = 1'b0; burst_len = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_read_cmd", rc_a, 0);
    chk("rst_data_out", dout_a, 0);
    chk("rst_valid", dv_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_count", cnt_a, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Asynchronous reset while holding, pending pop dropped
    load_a(6); load_a(7);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("t1_pop_strobe", rc_a, 1);
    chk("t1_data", dout_a, 6);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async_read_cmd", rc_a, 0);
    chk("t1_async_data_out", dout_a, 0);
    chk("t1_async_valid", dv_a, 0);
    chk("t1_async_busy", busy_a, 0);
    chk("t1_async_done", done_a, 0);
    chk("t1_async_count", cnt_a, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    chk("t1_entries_left", wa - ra, 2);
    flush_queue_a();

    // Table: burst_len=2 over queue {3,4,5}
    load_a(3); load_a(4); load_a(5);
    burst_len = CW'(2);
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].start, tbl[i].abort, tbl[i].tick);
      chk($sformatf("t2_v%0d_read_cmd", i), rc_a, tbl[i].rc);
      chk($sformatf("t2_v%0d_valid", i), dv_a, tbl[i].dv);
      chk($sformatf("t2_v%0d_data_out", i), dout_a, tbl[i].dout);
      chk($sformatf("t2_v%0d_busy", i), busy_a, tbl[i].busy);
      chk($sformatf("t2_v%0d_done", i), done_a, tbl[i].done);
      chk($sformatf("t2_v%0d_count", i), cnt_a, tbl[i].cnt);
    end
    abort = 1'b0;
    chk("t2_entries_left", wa - ra, 1);
    flush_queue_a();

    // Drain-until-empty over {7,8}
    load_a(7); load_a(8);
    burst_len = '0;
    cyc(1, 0, 0);
    npop = 0; ndone = 0;
    for (int i = 0; i < 40 && ndone == 0; i++) begin
      cyc(0, 0, 1);
      if (dv_a && npop < 4) seen[npop] = int'(dout_a);
      if (rc_a) npop++;
      if (done_a) ndone++;
    end
    chk("t3_done_seen", ndone, 1);
    chk("t3_pops", npop, 2);
    chk("t3_first", seen[0], 7);
    chk("t3_second", seen[1], 8);
    chk("t3_count", cnt_a, 2);
    chk("t3_entries_left", wa - ra, 0);
    cyc(0, 0, 0);

    // Empty queue: POP then DONE, done at start+2
    cyc(1, 0, 0);
    chk("t4_busy", busy_a, 1);
    chk("t4_done_early", done_a, 0);
    cyc(0, 0, 0);
    chk("t4_done", done_a, 1);
    chk("t4_read_cmd", rc_a, 0);
    chk("t4_count", cnt_a, 0);
    chk("t4_busy_off", busy_a, 0);
    chk("t4_data_kept", dout_a, 8);
    cyc(0, 0, 0);
    chk("t4_done_pulse", done_a, 0);

    // Abort during first hold over {1,2,3}
    load_a(1); load_a(2); load_a(3);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("t5_read_cmd", rc_a, 1);
    chk("t5_data", dout_a, 1);
    cyc(0, 0, 1);
    chk("t5_holding", busy_a, 1);
    cyc(0, 1, 0);
    chk("t5_abort_busy", busy_a, 0);
    chk("t5_abort_done", done_a, 0);
    cyc(0, 0, 0);
    chk("t5_no_done", done_a, 0);
    chk("t5_no_pop", rc_a, 0);
    chk("t5_data_kept", dout_a, 1);
    chk("t5_count", cnt_a, 1);
    chk("t5_entries_left", wa - ra, 2);
    flush_queue_a();

    // Pacing on instance B: hold 3, tick every 4 clocks, start mid-hold ignored
    load_b(9); load_b(10); load_b(11);
    burst_len = CW'(3);
    npop = 0; done_idx = -1;
    for (int i = 0; i < 40; i++) begin
      cyc(i == 0 || i == 5, 0, (i % 4) == 3);
      if (rc_b && npop < 4) begin
        pop_idx[npop] = i;
        seen[npop] = int'(dout_b);
        npop++;
      end
      if (done_b) done_idx = i;
    end
    chk("t6_pops", npop, 3);
    chk("t6_pop0_cycle", pop_idx[0], 1);
    chk("t6_pop1_cycle", pop_idx[1], 12);
    chk("t6_pop2_cycle", pop_idx[2], 24);
    chk("t6_data0", seen[0], 9);
    chk("t6_data2", seen[2], 11);
    chk("t6_done_cycle", done_idx, 35);
    chk("t6_count", cnt_b, 3);
    chk("t6_entries_left", wb - rb, 0);

    chk("pop_while_empty", bad_pops, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_queue_reader
`default_nettype wire
